// File: rtl/conv_mac_array_if.sv
// Handshake/data bundle for conv_mac_array: packed lane samples, weights,
// biases and the per-window result beat with its status flags.
interface conv_mac_array_if #(
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32,
  parameter int NUM_CH = 4
);
  logic [NUM_CH*IN_W-1:0]  input_port;
  logic [NUM_CH*IN_W-1:0]  weight;
  logic [NUM_CH*ACC_W-1:0] bias;
  logic                    valid;
  logic [NUM_CH*ACC_W-1:0] output_port;
  logic                    out_valid;
  logic                    finish;
  logic                    invalid;

  modport master (
    output input_port, weight, bias, valid,
    input  output_port, out_valid, finish, invalid
  );

  modport slave (
    input  input_port, weight, bias, valid,
    output output_port, out_valid, finish, invalid
  );
endinterface

// File: rtl/conv_mac_array.sv
// Multi-lane saturating convolution MAC: KERNEL_LEN products per window onto a bias,
// NUM_WIN windows per layer. Optional output ReLU via macro CONV_MAC_RELU_EN.
module conv_mac_array #(
  parameter int IN_W       = 16,
  parameter int ACC_W      = 32,
  parameter int NUM_CH     = 4,
  parameter int KERNEL_LEN = 9,
  parameter int NUM_WIN    = 16
) (
  input  logic             h_clk,
  input  logic             reset,
  conv_mac_array_if.slave  bus
);

  localparam int BW = $clog2(KERNEL_LEN + 1);
  localparam int WW = $clog2(NUM_WIN + 1);

  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(KERNEL_LEN);
  localparam logic [WW-1:0] WIN_ONE   = WW'(1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(NUM_WIN);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCUM  = 3'd1;
  localparam logic [2:0] ST_OUTPUT = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat_add = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_add = sum[ACC_W-1:0];
    end
  endfunction

  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef CONV_MAC_RELU_EN
    if (v[ACC_W-1]) begin
      relu = {ACC_W{1'b0}};
    end else begin
      relu = v;
    end
`else
    relu = v;
`endif
  endfunction

  logic [2:0]              state_q, state_d;
  logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [WW-1:0]           win_cnt_q, win_cnt_d;
  logic signed [ACC_W-1:0] acc_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_d [NUM_CH];
  logic [NUM_CH*ACC_W-1:0] out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    finish_q, finish_d;
  logic                    invalid_q, invalid_d;

  logic signed [ACC_W-1:0] start_acc_s [NUM_CH];
  logic signed [ACC_W-1:0] step_acc_s  [NUM_CH];
  logic [NUM_CH*ACC_W-1:0] start_out_s, step_out_s;
  logic [BW-1:0]           beat_nxt_s;
  logic [WW-1:0]           win_nxt_s;
  logic                    start_win_s, step_win_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    logic signed [IN_W-1:0]   in_s, wt_s;
    logic signed [2*IN_W-1:0] mul_s;
    logic signed [ACC_W-1:0]  prod_s, bias_s;
    assign in_s   = bus.input_port[g*IN_W +: IN_W];
    assign wt_s   = bus.weight[g*IN_W +: IN_W];
    assign bias_s = bus.bias[g*ACC_W +: ACC_W];
    assign mul_s  = in_s * wt_s;
    assign prod_s = ACC_W'(mul_s);
    assign start_acc_s[g] = sat_add(bias_s, prod_s);
    assign step_acc_s[g]  = sat_add(acc_q[g], prod_s);
  end

  assign beat_nxt_s = beat_cnt_q + BEAT_ONE;
  assign win_nxt_s  = win_cnt_q + WIN_ONE;

  // Pack the candidate window results (post-ReLU) for the output register.
  always_comb begin
    start_out_s = {(NUM_CH*ACC_W){1'b0}};
    step_out_s  = {(NUM_CH*ACC_W){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      start_out_s[i*ACC_W +: ACC_W] = relu(start_acc_s[i]);
      step_out_s[i*ACC_W +: ACC_W]  = relu(step_acc_s[i]);
    end
  end

  // Next-state logic; a window start from IDLE or OUTPUT shares one reload path.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    win_cnt_d   = win_cnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    finish_d    = finish_q;
    invalid_d   = invalid_q;
    start_win_s = 1'b0;
    step_win_s  = 1'b0;

    case (state_q)
      ST_IDLE:  start_win_s = bus.valid;
      ST_ACCUM: step_win_s  = bus.valid;
      ST_OUTPUT: begin
        win_cnt_d = win_nxt_s;
        if (win_nxt_s == WIN_LAST) begin
          finish_d = 1'b1;
          if (bus.valid) begin
            state_d   = ST_ERROR;
            invalid_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (bus.valid) begin
          start_win_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (bus.valid) begin
          state_d   = ST_ERROR;
          invalid_d = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ERROR: begin
        state_d   = ST_ERROR;
        invalid_d = 1'b1;
      end
      default: begin
        state_d   = ST_ERROR;
        invalid_d = 1'b1;
      end
    endcase

    // The result register is loaded on the edge that accepts the final beat,
    // so out_valid is high during the OUTPUT cycle itself.
    if (start_win_s) begin
      acc_d      = start_acc_s;
      beat_cnt_d = BEAT_ONE;
      if (KERNEL_LEN == 1) begin
        state_d     = ST_OUTPUT;
        out_valid_d = 1'b1;
        out_d       = start_out_s;
      end else begin
        state_d = ST_ACCUM;
      end
    end else if (step_win_s) begin
      acc_d      = step_acc_s;
      beat_cnt_d = beat_nxt_s;
      if (beat_nxt_s == BEAT_LAST) begin
        state_d     = ST_OUTPUT;
        out_valid_d = 1'b1;
        out_d       = step_out_s;
      end else begin
        state_d = ST_ACCUM;
      end
    end else begin
      beat_cnt_d = beat_cnt_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge h_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= {BW{1'b0}};
      win_cnt_q   <= {WW{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= {ACC_W{1'b0}};
      end
      out_q       <= {(NUM_CH*ACC_W){1'b0}};
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      win_cnt_q   <= win_cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      finish_q    <= finish_d;
      invalid_q   <= invalid_d;
    end
  end

  assign bus.output_port = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.finish      = finish_q;
  assign bus.invalid     = invalid_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// Randomised self-checking bench for conv_mac_array: a default-sized instance
// (9-beat kernel, 16 windows) and a 1-beat / 2-window instance for completion paths.
module tb_conv_mac_array;

  localparam int IN_W   = 16;
  localparam int ACC_W  = 32;
  localparam int NUM_CH = 4;
  localparam int KL     = 9;
  localparam int NW     = 16;

  logic h_clk = 1'b0;
  logic rst_a, rst_b;

  always #5 h_clk = ~h_clk;

  conv_mac_array_if #(.IN_W(IN_W), .ACC_W(ACC_W), .NUM_CH(NUM_CH)) bus_a ();
  conv_mac_array_if #(.IN_W(IN_W), .ACC_W(ACC_W), .NUM_CH(NUM_CH)) bus_b ();

  conv_mac_array #(
    .IN_W(IN_W), .ACC_W(ACC_W), .NUM_CH(NUM_CH), .KERNEL_LEN(KL), .NUM_WIN(NW)
  ) u_dut (
    .h_clk(h_clk), .reset(rst_a), .bus(bus_a)
  );

  conv_mac_array #(
    .IN_W(IN_W), .ACC_W(ACC_W), .NUM_CH(NUM_CH), .KERNEL_LEN(1), .NUM_WIN(2)
  ) u_small (
    .h_clk(h_clk), .reset(rst_b), .bus(bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int win_a [KL][NUM_CH];
  int win_w [KL][NUM_CH];
  int win_b [NUM_CH];
  logic [31:0] exp_lane [NUM_CH];

  int sa [NUM_CH];
  int sw [NUM_CH];
  int sb [NUM_CH];
  logic [31:0] sexp [NUM_CH];
  logic [31:0] sprev [NUM_CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: clamp to 32-bit signed range, optional ReLU on output only.
  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint relu_m(input longint v);
`ifdef CONV_MAC_RELU_EN
    if (v < 0) return 0;
`endif
    return v;
  endfunction

  function automatic int rand_in();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic compute_expected();
    longint acc;
    for (int i = 0; i < NUM_CH; i++) begin
      acc = longint'(win_b[i]);
      for (int k = 0; k < KL; k++) begin
        acc = sat32(acc + longint'(win_a[k][i]) * longint'(win_w[k][i]));
      end
      exp_lane[i] = 32'(relu_m(acc));
    end
  endtask

  task automatic fill_random();
    int r;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < KL; k++) begin
        win_a[k][i] = rand_in();
        win_w[k][i] = rand_in();
      end
      r = int'($urandom_range(0, 3));
      if (r == 0) win_b[i] = 32'h7FFF0000;
      else if (r == 1) win_b[i] = 32'h80000000;
      else win_b[i] = int'($urandom);
    end
  endtask

  task automatic fill_const(input int a, input int w, input int b);
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < KL; k++) begin
        win_a[k][i] = a;
        win_w[k][i] = w;
      end
      win_b[i] = b;
    end
  endtask

  task automatic drive_a(input int k);
    for (int i = 0; i < NUM_CH; i++) begin
      bus_a.input_port[i*IN_W +: IN_W] = 16'(win_a[k][i]);
      bus_a.weight[i*IN_W +: IN_W]     = 16'(win_w[k][i]);
      bus_a.bias[i*ACC_W +: ACC_W]     = 32'(win_b[i]);
    end
    bus_a.valid = 1'b1;
  endtask

  task automatic idle_a(input int n);
    bus_a.valid = 1'b0;
    repeat (n) begin
      @(posedge h_clk);
      @(negedge h_clk);
    end
  endtask

  // Drives one window (optionally with bubbles) and checks the result in the
  // cycle right after the last beat; returns positioned in that OUTPUT cycle.
  task automatic run_window_a(input int bubble_pct, input string tag);
    int nb;
    compute_expected();
    for (int k = 0; k < KL; k++) begin
      if (k > 0 && bubble_pct > 0 && int'($urandom_range(0, 99)) < bubble_pct) begin
        nb = int'($urandom_range(1, 3));
        bus_a.valid      = 1'b0;
        bus_a.input_port = {$urandom, $urandom};
        bus_a.weight     = {$urandom, $urandom};
        repeat (nb) begin
          @(posedge h_clk);
          @(negedge h_clk);
        end
        check_eq({tag, "_bubble_ov"}, 32'(bus_a.out_valid), 32'd0);
      end
      drive_a(k);
      @(posedge h_clk);
      @(negedge h_clk);
      if (k < KL - 1) begin
        check_eq({tag, "_early_ov"}, 32'(bus_a.out_valid), 32'd0);
      end
    end
    bus_a.valid = 1'b0;
    check_eq({tag, "_ov"}, 32'(bus_a.out_valid), 32'd1);
    for (int i = 0; i < NUM_CH; i++) begin
      check_eq($sformatf("%s_lane%0d", tag, i), bus_a.output_port[i*ACC_W +: ACC_W], exp_lane[i]);
    end
  endtask

  task automatic drive_b();
    longint v;
    for (int i = 0; i < NUM_CH; i++) begin
      sa[i] = rand_in();
      sw[i] = rand_in();
      sb[i] = int'($urandom);
      v = relu_m(sat32(longint'(sb[i]) + longint'(sa[i]) * longint'(sw[i])));
      sprev[i] = sexp[i];
      sexp[i]  = 32'(v);
      bus_b.input_port[i*IN_W +: IN_W] = 16'(sa[i]);
      bus_b.weight[i*IN_W +: IN_W]     = 16'(sw[i]);
      bus_b.bias[i*ACC_W +: ACC_W]     = 32'(sb[i]);
    end
    bus_b.valid = 1'b1;
  endtask

  task automatic step_b();
    @(posedge h_clk);
    @(negedge h_clk);
  endtask

  task automatic check_b_result(input string tag);
    check_eq({tag, "_ov"}, 32'(bus_b.out_valid), 32'd1);
    for (int i = 0; i < NUM_CH; i++) begin
      check_eq($sformatf("%s_lane%0d", tag, i), bus_b.output_port[i*ACC_W +: ACC_W], sexp[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_c;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.valid = 1'b0; bus_a.input_port = '0; bus_a.weight = '0; bus_a.bias = '0;
    bus_b.valid = 1'b0; bus_b.input_port = '0; bus_b.weight = '0; bus_b.bias = '0;
    for (int i = 0; i < NUM_CH; i++) sexp[i] = 32'd0;
    repeat (2) @(posedge h_clk);
    @(negedge h_clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    check_eq("rst_ov", 32'(bus_a.out_valid), 32'd0);
    check_eq("rst_finish", 32'(bus_a.finish), 32'd0);
    check_eq("rst_invalid", 32'(bus_a.invalid), 32'd0);
    for (int i = 0; i < NUM_CH; i++) begin
      check_eq($sformatf("rst_lane%0d", i), bus_a.output_port[i*ACC_W +: ACC_W], 32'd0);
    end

    // Basic window: 10 + 9*6 = 64 on every lane.
    fill_const(2, 3, 10);
    run_window_a(0, "basic");
    check_eq("basic_64", bus_a.output_port[ACC_W-1:0], 32'd64);
    idle_a(2);
    check_eq("hold_ov", 32'(bus_a.out_valid), 32'd0);
    check_eq("hold_lane0", bus_a.output_port[ACC_W-1:0], 32'd64);

    // Random data with bubbles, second window starts in the OUTPUT cycle.
    fill_random();
    run_window_a(40, "bub1");
    fill_random();
    run_window_a(40, "bub2");
    idle_a(1);
    check_eq("b2b_idle_ov", 32'(bus_a.out_valid), 32'd0);

    // Saturation in both directions on lanes 0/1.
    fill_random();
    for (int k = 0; k < KL; k++) begin
      win_a[k][0] = 32767;  win_w[k][0] = 32767;
      win_a[k][1] = -32768; win_w[k][1] = 32767;
    end
    win_b[0] = 32'h7FFF0000;
    win_b[1] = 32'h80000000;
    run_window_a(0, "sat");
    check_eq("sat_pos", bus_a.output_port[ACC_W-1:0], 32'h7FFFFFFF);
`ifdef CONV_MAC_RELU_EN
    exp_c = 32'h00000000;
`else
    exp_c = 32'h80000000;
`endif
    check_eq("sat_neg", bus_a.output_port[2*ACC_W-1:ACC_W], exp_c);
    idle_a(1);

    // Negative result: -45 raw, 0 with ReLU.
    fill_const(-1, 5, 0);
    run_window_a(0, "neg");
`ifdef CONV_MAC_RELU_EN
    exp_c = 32'h00000000;
`else
    exp_c = 32'hFFFFFFD3;
`endif
    check_eq("neg_const", bus_a.output_port[ACC_W-1:0], exp_c);
    idle_a(1);

    // Reset in the middle of a window discards the partial sums and win_cnt.
    fill_random();
    for (int k = 0; k < 5; k++) begin
      drive_a(k);
      @(posedge h_clk);
      @(negedge h_clk);
    end
    bus_a.valid = 1'b0;
    rst_a = 1'b1;
    @(posedge h_clk);
    @(negedge h_clk);
    rst_a = 1'b0;
    check_eq("mid_rst_lane0", bus_a.output_port[ACC_W-1:0], 32'd0);
    check_eq("mid_rst_ov", 32'(bus_a.out_valid), 32'd0);
    fill_const(1, 1, 0);
    run_window_a(0, "post_rst");
    check_eq("post_rst_9", bus_a.output_port[ACC_W-1:0], 32'd9);
    check_eq("post_rst_finish", 32'(bus_a.finish), 32'd0);
    check_eq("post_rst_invalid", 32'(bus_a.invalid), 32'd0);

    // Remaining windows up to NUM_WIN, randomly back-to-back or separated.
    for (int n = 2; n <= NW; n++) begin
      if ($urandom_range(0, 1) == 1) idle_a(int'($urandom_range(1, 3)));
      fill_random();
      run_window_a(20, $sformatf("w%0d", n));
      if (n < NW) check_eq("pre_finish", 32'(bus_a.finish), 32'd0);
    end
    check_eq("last_out_finish", 32'(bus_a.finish), 32'd0);
    idle_a(1);
    check_eq("done_finish", 32'(bus_a.finish), 32'd1);
    check_eq("done_invalid", 32'(bus_a.invalid), 32'd0);
    check_eq("done_ov", 32'(bus_a.out_valid), 32'd0);
    idle_a(2);
    check_eq("done_hold_finish", 32'(bus_a.finish), 32'd1);
    fill_random();
    drive_a(0);
    @(posedge h_clk);
    @(negedge h_clk);
    bus_a.valid = 1'b0;
    check_eq("err_invalid", 32'(bus_a.invalid), 32'd1);
    check_eq("err_finish", 32'(bus_a.finish), 32'd1);
    check_eq("err_ov", 32'(bus_a.out_valid), 32'd0);
    idle_a(2);
    check_eq("err_hold_invalid", 32'(bus_a.invalid), 32'd1);
    check_eq("err_hold_ov", 32'(bus_a.out_valid), 32'd0);

    // Small instance: two 1-beat windows, the second in the OUTPUT cycle.
    drive_b();
    step_b();
    check_b_result("s_w1");
    drive_b();
    step_b();
    bus_b.valid = 1'b0;
    check_b_result("s_w2");
    check_eq("s_w2_finish", 32'(bus_b.finish), 32'd0);
    step_b();
    check_eq("s_done_finish", 32'(bus_b.finish), 32'd1);
    check_eq("s_done_ov", 32'(bus_b.out_valid), 32'd0);
    check_eq("s_done_invalid", 32'(bus_b.invalid), 32'd0);
    drive_b();
    step_b();
    bus_b.valid = 1'b0;
    check_eq("s_err_invalid", 32'(bus_b.invalid), 32'd1);
    check_eq("s_err_finish", 32'(bus_b.finish), 32'd1);
    check_eq("s_err_ov", 32'(bus_b.out_valid), 32'd0);
    step_b();
    check_eq("s_err_hold_ov", 32'(bus_b.out_valid), 32'd0);

    // Extra beat arriving during the final OUTPUT cycle: result kept, beat dropped.
    rst_b = 1'b1;
    step_b();
    rst_b = 1'b0;
    check_eq("s_rst_invalid", 32'(bus_b.invalid), 32'd0);
    check_eq("s_rst_finish", 32'(bus_b.finish), 32'd0);
    drive_b();
    step_b();
    check_b_result("s2_w1");
    drive_b();
    step_b();
    check_b_result("s2_w2");
    drive_b();
    step_b();
    bus_b.valid = 1'b0;
    check_eq("s2_err_invalid", 32'(bus_b.invalid), 32'd1);
    check_eq("s2_err_ov", 32'(bus_b.out_valid), 32'd0);
    check_eq("s2_hold_lane0", bus_b.output_port[ACC_W-1:0], sprev[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
